serial_divider: RTL and testbench
=================================

// Module: serial_divider
// PURPOSE
//  Wishbone-B4 slave wrapping an unsigned radix-2 restoring serial divider (1 quotient bit/clk).
//  Software writes dividend/divisor, starts the divide, then polls status and reads quotient/remainder.
//  Selected operand/result is mirrored onto the logic analyzer bus; two blink outputs give board-level life signs.
//  Sits in the user project area behind the SoC Wishbone master.
// PARAMETERS
//  WBW          32      Wishbone data/address width
//  LAW          32      la_data_o width; value zero-extended/truncated from XLEN
//  XLEN         32      dividend/divisor/quotient/remainder width
//  BLINK_CYCLES 32_000  hw_blinky_o period in clk_i cycles
// PORTS
//  clk_i        in   1        system clock
//  reset_i      in   1        reset (one clock; reset is asynchronous, active-high)
//  wbs_stb_i    in   1        WB strobe
//  wbs_cyc_i    in   1        WB cycle
//  wbs_we_i     in   1        WB write enable
//  wbs_sel_i    in   WBW/8    WB byte lanes
//  wbs_adr_i    in   WBW      WB byte address
//  wbs_dat_i    in   WBW      WB write data
//  wbs_ack_o    out  1        WB acknowledge
//  wbs_dat_o    out  WBW      WB read data
//  la_data_o    out  LAW      LA observation bus
//  hw_blinky_o  out  1        free-running blink
//  sw_blinky_o  out  1        software-controlled LED
//  start_o      out  1        1-clk pulse when a divide starts
//  fini_o       out  1        result valid
//  hw_sel_i     in   4        [1:0] LA select, [2] auto-start, [3] LA mux enable
// BEHAVIOUR
//  Reset: all regs, wbs_ack_o, wbs_dat_o, la_data_o, blinkies, start_o, fini_o = 0; state IDLE.
//  WB: request = stb&cyc&~ack; ack registered 1 clk later, 1-clk pulse, never back-to-back.
//  Write honours wbs_sel_i per byte. Read data valid with ack; 0 elsewhere.
//  Decode: ARG region adr[31:28]!=0, CTRL region adr[27:24]!=0, word offset adr[3:2].
//   ARG 0 dividend RW, 1 divisor RW, 2 quotient RO, 3 remainder RO.
//   CTRL 0 control: bit0 start (write-1, self-clearing), bit1 sw_blinky; 1 status RO {fini,busy}.
//   Both regions or neither: no write, read 0, still acked.
//  FSM IDLE->RUN on start (CTRL bit0 write, or divisor write while hw_sel_i[2]=1); start_o pulses that clk.
//  RUN: XLEN iterations shift/compare/subtract -> DONE; fini_o=1 in DONE until next start (then 0).
//  start, dividend/divisor writes while RUN: ignored. Start from DONE allowed.
//  Divisor 0: quotient all ones, remainder = dividend, same latency.
//  Latency: fini_o high XLEN+1 clks after start_o.
//  reset_i mid-RUN: abort, all state cleared.
//  la_data_o (registered): hw_sel_i[3]=1 -> [1:0] 00 divisor,01 dividend,10 quotient,11 remainder.
//   hw_sel_i[3]=0 -> see CONFIGURATION.
//  hw_blinky_o toggles every BLINK_CYCLES/2 clks; sw_blinky_o = control bit1.
// CONFIGURATION
//  SERIAL_DIVIDER_DEBUG_EN defined: hw_sel_i[3]=0 puts {state,iteration count,busy,fini} on la_data_o LSBs.
//  Not defined: hw_sel_i[3]=0 drives la_data_o=0; no debug logic.
// STRUCTURE
//  Package serial_divider_pkg: LA select codes (SELDIVISOR..SELREMAINDER), region/offset constants, FSM state enum.
//  Sub-module serial_divider_core: start/dividend/divisor in, quotient/remainder/busy/done out.
//  Top: WB decode, registers, LA mux, blink counter.
// TESTING
//  Write dividend 16, divisor 4, ctrl 1 (hw_sel 4'b1010) -> start_o pulse; after XLEN+1 clks fini_o=1, la_data_o=4, rem 0.
//  100/7 -> quotient 14, remainder 2 via WB reads; status reads 2'b10.
//  Divisor 0, dividend 0x1234 -> quotient 0xFFFF_FFFF, remainder 0x1234.
//  Start while busy + operand writes mid-RUN -> ignored, original result intact.
//  hw_sel_i[2]=1, write divisor -> auto start; reset_i mid-RUN -> fini_o=0, all regs 0.
//  Single WB access -> exactly one 1-clk ack; sel=4'b0001 write alters only byte 0.

Source files
------------

// File: rtl/serial_divider_pkg.sv
// Shared constants for the serial divider: LA select codes, register
// offsets inside the ARG and CTRL regions, and the divider FSM states.
package serial_divider_pkg;

  localparam logic [1:0] SELDIVISOR   = 2'b00;
  localparam logic [1:0] SELDIVIDEND  = 2'b01;
  localparam logic [1:0] SELQUOTIENT  = 2'b10;
  localparam logic [1:0] SELREMAINDER = 2'b11;

  localparam logic [1:0] ARG_DIVIDEND  = 2'd0;
  localparam logic [1:0] ARG_DIVISOR   = 2'd1;
  localparam logic [1:0] ARG_QUOTIENT  = 2'd2;
  localparam logic [1:0] ARG_REMAINDER = 2'd3;

  localparam logic [1:0] CTRL_CONTROL = 2'd0;
  localparam logic [1:0] CTRL_STATUS  = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } divState_e;

endpackage

// File: rtl/serial_divider_core.sv
// Unsigned radix-2 restoring divider producing one quotient bit per clock.
// Operands are captured on start. A zero divisor needs no special case:
// every trial subtraction succeeds, which leaves an all-ones quotient and
// the dividend as the remainder after the usual number of iterations.
module serial_divider_core
  import serial_divider_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CW   = $clog2(XLEN + 1)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            busy_o,
  output logic            done_o,
  output divState_e       state_o,
  output logic [CW-1:0]   count_o
);

  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  divState_e       state_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] div_q;
  logic [CW-1:0]   count_q;
  logic            busy_q;
  logic            done_q;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  // Shift the next dividend bit into the partial remainder and try subtracting the divisor
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, div_q};
  end

  // Divider FSM: capture operands on start, iterate XLEN times, then hold the result
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q <= RUN;
            rem_q   <= '0;
            quo_q   <= dividend_i;
            div_q   <= divisor_i;
            count_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          rem_q   <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
          quo_q   <= {quo_q[XLEN-2:0], ~trial[XLEN]};
          count_q <= count_q + CW'(1);
          if (count_q == LAST_ITER) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign state_o     = state_q;
  assign count_o     = count_q;

endmodule

// File: rtl/serial_divider.sv
// Wishbone slave around the serial divider core: register file, start
// logic, LA observation mux and the two blink outputs.
// Optional debug view on la_data_o is built when SERIAL_DIVIDER_DEBUG_EN
// is defined; otherwise the non-selected LA bus reads as zero.
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int WBW          = 32,
  parameter int LAW          = 32,
  parameter int XLEN         = 32,
  parameter int BLINK_CYCLES = 32_000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [WBW/8-1:0] wbs_sel_i,
  input  logic [WBW-1:0]   wbs_adr_i,
  input  logic [WBW-1:0]   wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [WBW-1:0]   wbs_dat_o,
  output logic [LAW-1:0]   la_data_o,
  output logic             hw_blinky_o,
  output logic             sw_blinky_o,
  output logic             start_o,
  output logic             fini_o,
  input  logic [3:0]       hw_sel_i
);

  localparam int          CW         = $clog2(XLEN + 1);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES / 2 - 1);

  logic            ack_q, ack_d;
  logic [WBW-1:0]  rdat_q, rdat_d;
  logic [XLEN-1:0] dividend_q, dividend_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic            swBlinky_q, swBlinky_d;
  logic            startPulse_q, startPulse_d;
  logic [LAW-1:0]  la_q, la_d;
  logic [31:0]     blinkCnt_q;
  logic            hwBlinky_q;

  logic            request;
  logic            argSel;
  logic            ctrlSel;
  logic [1:0]      wordOff;
  logic            startReq;
  logic [XLEN-1:0] laVal;

  logic [XLEN-1:0] coreQuotient;
  logic [XLEN-1:0] coreRemainder;
  logic            coreBusy;
  logic            coreDone;
  divState_e       coreState;
  logic [CW-1:0]   coreCount;

  function automatic logic [XLEN-1:0] mergeBytes(input logic [XLEN-1:0]  old,
                                                 input logic [WBW-1:0]   dat,
                                                 input logic [WBW/8-1:0] sel);
    logic [WBW-1:0] res;
    res = WBW'(old);
    for (int b = 0; b < WBW / 8; b++) begin
      if (sel[b]) res[b*8 +: 8] = dat[b*8 +: 8];
    end
    return XLEN'(res);
  endfunction

  assign request = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign argSel  = (|wbs_adr_i[31:28]) & ~(|wbs_adr_i[27:24]);
  assign ctrlSel = ~(|wbs_adr_i[31:28]) & (|wbs_adr_i[27:24]);
  assign wordOff = wbs_adr_i[3:2];

  // Bus decode: one ack per request, gated register writes, read data only alongside ack
  always_comb begin
    ack_d        = 1'b0;
    rdat_d       = '0;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    swBlinky_d   = swBlinky_q;
    startReq     = 1'b0;
    if (request) begin
      ack_d = 1'b1;
      if (wbs_we_i) begin
        if (argSel && !coreBusy) begin
          case (wordOff)
            ARG_DIVIDEND: dividend_d = mergeBytes(dividend_q, wbs_dat_i, wbs_sel_i);
            ARG_DIVISOR: begin
              divisor_d = mergeBytes(divisor_q, wbs_dat_i, wbs_sel_i);
              startReq  = hw_sel_i[2];
            end
            default: ;
          endcase
        end else if (ctrlSel && wordOff == CTRL_CONTROL && wbs_sel_i[0]) begin
          swBlinky_d = wbs_dat_i[1];
          startReq   = wbs_dat_i[0];
        end
      end else if (argSel) begin
        case (wordOff)
          ARG_DIVIDEND:  rdat_d = WBW'(dividend_q);
          ARG_DIVISOR:   rdat_d = WBW'(divisor_q);
          ARG_QUOTIENT:  rdat_d = WBW'(coreQuotient);
          ARG_REMAINDER: rdat_d = WBW'(coreRemainder);
          default:       rdat_d = '0;
        endcase
      end else if (ctrlSel) begin
        case (wordOff)
          CTRL_CONTROL: rdat_d = WBW'({swBlinky_q, 1'b0});
          CTRL_STATUS:  rdat_d = WBW'({coreDone, coreBusy});
          default:      rdat_d = '0;
        endcase
      end
    end
    startPulse_d = startReq & ~coreBusy & ~startPulse_q;
  end

  // Logic analyzer view: selected operand/result, or the optional debug word
  always_comb begin
    laVal = '0;
    if (hw_sel_i[3]) begin
      case (hw_sel_i[1:0])
        SELDIVISOR:   laVal = divisor_q;
        SELDIVIDEND:  laVal = dividend_q;
        SELQUOTIENT:  laVal = coreQuotient;
        SELREMAINDER: laVal = coreRemainder;
        default:      laVal = '0;
      endcase
    end else begin
`ifdef SERIAL_DIVIDER_DEBUG_EN
      laVal = XLEN'({coreState, coreCount, coreBusy, coreDone});
`else
      laVal = '0;
`endif
    end
    la_d = LAW'(laVal);
  end

  // Register file, bus response and start pulse
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ack_q        <= 1'b0;
      rdat_q       <= '0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      swBlinky_q   <= 1'b0;
      startPulse_q <= 1'b0;
      la_q         <= '0;
    end else begin
      ack_q        <= ack_d;
      rdat_q       <= rdat_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      swBlinky_q   <= swBlinky_d;
      startPulse_q <= startPulse_d;
      la_q         <= la_d;
    end
  end

  // Free-running blink: toggle every half period
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      blinkCnt_q <= '0;
      hwBlinky_q <= 1'b0;
    end else if (blinkCnt_q >= BLINK_LAST) begin
      blinkCnt_q <= '0;
      hwBlinky_q <= ~hwBlinky_q;
    end else begin
      blinkCnt_q <= blinkCnt_q + 32'd1;
    end
  end

  serial_divider_core #(
    .XLEN (XLEN),
    .CW   (CW)
  ) u_core (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (startPulse_q),
    .dividend_i  (dividend_q),
    .divisor_i   (divisor_q),
    .quotient_o  (coreQuotient),
    .remainder_o (coreRemainder),
    .busy_o      (coreBusy),
    .done_o      (coreDone),
    .state_o     (coreState),
    .count_o     (coreCount)
  );

  logic unusedBits;
`ifdef SERIAL_DIVIDER_DEBUG_EN
  assign unusedBits = ^{wbs_adr_i[23:4], wbs_adr_i[1:0]};
`else
  assign unusedBits = ^{wbs_adr_i[23:4], wbs_adr_i[1:0], coreState, coreCount};
`endif

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = rdat_q;
  assign la_data_o   = la_q;
  assign hw_blinky_o = hwBlinky_q;
  assign sw_blinky_o = swBlinky_q;
  assign start_o     = startPulse_q;
  assign fini_o      = coreDone;

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider: Wishbone accesses, divide results
// against a behavioural model through a result queue, start/fini timing,
// busy protection, reset abort, byte lanes, decode and blink outputs.
module tb_serial_divider;

  localparam int XLEN  = 32;
  localparam int BLINK = 8;
  localparam logic [31:0] ADR_DIVIDEND  = 32'h1000_0000;
  localparam logic [31:0] ADR_DIVISOR   = 32'h1000_0004;
  localparam logic [31:0] ADR_QUOTIENT  = 32'h1000_0008;
  localparam logic [31:0] ADR_REMAINDER = 32'h1000_000C;
  localparam logic [31:0] ADR_CONTROL   = 32'h0100_0000;
  localparam logic [31:0] ADR_STATUS    = 32'h0100_0004;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, datIn = '0;
  logic        ack;
  logic [31:0] datOut;
  logic [31:0] laData;
  logic        hwBlinky, swBlinky, startO, finiO;
  logic [3:0]  hwSel = 4'b0000;

  int compared   = 0;
  int mismatched = 0;
  logic [63:0] scoreboard[$];

  int   negCnt = 0, startPulses = 0, startNeg = 0, finiNeg = 0;
  logic finiPrev = 1'b0;

  always #5 clock = ~clock;

  serial_divider #(
    .WBW(32), .LAW(32), .XLEN(XLEN), .BLINK_CYCLES(BLINK)
  ) dut (
    .clk_i(clock), .reset_i(reset),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(datIn), .wbs_ack_o(ack), .wbs_dat_o(datOut),
    .la_data_o(laData), .hw_blinky_o(hwBlinky), .sw_blinky_o(swBlinky),
    .start_o(startO), .fini_o(finiO), .hw_sel_i(hwSel)
  );

  // Watch start/fini on the falling edge to measure pulse counts and latency
  always @(negedge clock) begin
    negCnt++;
    if (startO) begin
      startPulses++;
      startNeg = negCnt;
    end
    if (finiO && !finiPrev) finiNeg = negCnt;
    finiPrev = finiO;
  end

  function automatic logic [63:0] modelDivide(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    return {a / b, a % b};
  endfunction

  // One Wishbone access; counts every ack seen, including any stray one after the access
  task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [31:0] rdata, output int acks);
    int waitCnt;
    acks = 0;
    rdata = '0;
    waitCnt = 0;
    @(negedge clock);
    stb = 1'b1; cyc = 1'b1; we = wr; adr = a; datIn = d; sel = s;
    while (acks == 0 && waitCnt < 10) begin
      @(posedge clock); #1;
      if (ack) begin
        acks++;
        rdata = datOut;
      end
      waitCnt++;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clock); #1;
    if (ack) acks++;
  endtask

  task automatic wbWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int acks);
    logic [31:0] dummy;
    applyStimulus(1'b1, a, d, s, dummy, acks);
  endtask

  task automatic wbRead(input logic [31:0] a, output logic [31:0] d);
    int acks;
    applyStimulus(1'b0, a, 32'd0, 4'hF, d, acks);
  endtask

  task automatic startDivide(input logic [31:0] a, input logic [31:0] b, output int acks);
    int ak;
    acks = 0;
    wbWrite(ADR_DIVIDEND, a, 4'hF, ak); acks += ak;
    wbWrite(ADR_DIVISOR, b, 4'hF, ak);  acks += ak;
    wbWrite(ADR_CONTROL, 32'd1, 4'hF, ak); acks += ak;
    scoreboard.push_back(modelDivide(a, b));
  endtask

  task automatic waitFini(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (finiO) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    @(negedge clock);
    compared++; if (ack !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ack: got %b expected 0", ack); end
    compared++; if (datOut !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_dat: got %h expected 0", datOut); end
    compared++; if (laData !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_la: got %h expected 0", laData); end
    compared++; if ({hwBlinky, swBlinky} !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_blinky: got %b expected 00", {hwBlinky, swBlinky}); end
    compared++; if ({startO, finiO} !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_start_fini: got %b expected 00", {startO, finiO}); end
    reset = 1'b0;
    wbRead(ADR_DIVIDEND, r);
    compared++; if (r !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_dividend: got %h expected 0", r); end
    wbRead(ADR_STATUS, r);
    compared++; if (r !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_status: got %h expected 0", r); end
  endtask

  task automatic test_basic();
    int acks, pulsesBefore;
    logic ok;
    logic [31:0] q, rm;
    logic [63:0] exp;
    hwSel = 4'b1010;
    pulsesBefore = startPulses;
    startDivide(32'd16, 32'd4, acks);
    compared++; if (acks != 3) begin mismatched++; $display("[TB] FAIL basic_acks: got %0d expected 3", acks); end
    compared++; if (startPulses != pulsesBefore + 1) begin mismatched++; $display("[TB] FAIL basic_start_pulse: got %0d expected %0d", startPulses - pulsesBefore, 1); end
    waitFini(ok);
    compared++; if (!ok) begin mismatched++; $display("[TB] FAIL basic_fini_timeout: got 0 expected 1"); end
    compared++; if (finiNeg - startNeg != XLEN + 1) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d expected %0d", finiNeg - startNeg, XLEN + 1); end
    compared++; if (laData !== 32'd4) begin mismatched++; $display("[TB] FAIL basic_la_quotient: got %h expected 4", laData); end
    wbRead(ADR_QUOTIENT, q);
    wbRead(ADR_REMAINDER, rm);
    exp = scoreboard.pop_front();
    compared++; if ({q, rm} !== exp) begin mismatched++; $display("[TB] FAIL basic_result: got %h expected %h", {q, rm}, exp); end
    hwSel = 4'b1011;
    @(negedge clock); @(negedge clock);
    compared++; if (laData !== 32'd0) begin mismatched++; $display("[TB] FAIL basic_la_remainder: got %h expected 0", laData); end
  endtask

  task automatic test_divide();
    int acks;
    logic ok;
    logic [31:0] q, rm, st;
    logic [63:0] exp;
    hwSel = 4'b0000;
    startDivide(32'd100, 32'd7, acks);
    wbRead(ADR_STATUS, st);
    compared++; if (st !== 32'd1) begin mismatched++; $display("[TB] FAIL div_status_busy: got %h expected 1", st); end
    waitFini(ok);
    compared++; if (!ok) begin mismatched++; $display("[TB] FAIL div_fini_timeout: got 0 expected 1"); end
    wbRead(ADR_STATUS, st);
    compared++; if (st !== 32'd2) begin mismatched++; $display("[TB] FAIL div_status_done: got %h expected 2", st); end
    wbRead(ADR_QUOTIENT, q);
    wbRead(ADR_REMAINDER, rm);
    exp = scoreboard.pop_front();
    compared++; if ({q, rm} !== exp) begin mismatched++; $display("[TB] FAIL div_100_7: got %h expected %h", {q, rm}, exp); end
  endtask

  task automatic test_div_zero();
    int acks;
    logic ok;
    logic [31:0] q, rm;
    logic [63:0] exp;
    startDivide(32'h1234, 32'd0, acks);
    waitFini(ok);
    compared++; if (finiNeg - startNeg != XLEN + 1) begin mismatched++; $display("[TB] FAIL div0_latency: got %0d expected %0d", finiNeg - startNeg, XLEN + 1); end
    wbRead(ADR_QUOTIENT, q);
    wbRead(ADR_REMAINDER, rm);
    exp = scoreboard.pop_front();
    compared++; if ({q, rm} !== exp) begin mismatched++; $display("[TB] FAIL div0_result: got %h expected %h", {q, rm}, exp); end
  endtask

  task automatic test_busy_ignore();
    int acks, pulsesBefore;
    logic ok;
    logic [31:0] q, rm, dv;
    logic [63:0] exp;
    startDivide(32'd1000, 32'd3, acks);
    pulsesBefore = startPulses;
    wbWrite(ADR_DIVIDEND, 32'd5, 4'hF, acks);
    wbWrite(ADR_DIVISOR, 32'd9, 4'hF, acks);
    wbWrite(ADR_CONTROL, 32'd1, 4'hF, acks);
    compared++; if (startPulses != pulsesBefore) begin mismatched++; $display("[TB] FAIL busy_restart: got %0d expected 0 extra pulses", startPulses - pulsesBefore); end
    wbRead(ADR_DIVIDEND, dv);
    compared++; if (dv !== 32'd1000) begin mismatched++; $display("[TB] FAIL busy_operand_write: got %h expected %h", dv, 32'd1000); end
    waitFini(ok);
    wbRead(ADR_QUOTIENT, q);
    wbRead(ADR_REMAINDER, rm);
    exp = scoreboard.pop_front();
    compared++; if ({q, rm} !== exp) begin mismatched++; $display("[TB] FAIL busy_result: got %h expected %h", {q, rm}, exp); end
  endtask

  task automatic test_back_to_back();
    int acks;
    logic ok;
    logic [31:0] a, b, q, rm;
    logic [63:0] exp;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = (i == 0) ? $urandom : $urandom_range(1, 5000);
      startDivide(a, b, acks);
      compared++; if (finiO !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_fini_clear_%0d: got %b expected 0", i, finiO); end
      waitFini(ok);
      wbRead(ADR_QUOTIENT, q);
      wbRead(ADR_REMAINDER, rm);
      if (scoreboard.size() == 0) begin
        compared++; mismatched++;
        $display("[TB] FAIL b2b_queue_%0d: got empty expected entry", i);
      end else begin
        exp = scoreboard.pop_front();
        compared++; if ({q, rm} !== exp) begin mismatched++; $display("[TB] FAIL b2b_result_%0d: got %h expected %h", i, {q, rm}, exp); end
      end
    end
  endtask

  task automatic test_auto_start_reset();
    int acks, pulsesBefore;
    logic [31:0] r;
    hwSel = 4'b0100;
    wbWrite(ADR_DIVIDEND, 32'd50, 4'hF, acks);
    pulsesBefore = startPulses;
    wbWrite(ADR_DIVISOR, 32'd5, 4'hF, acks);
    compared++; if (startPulses != pulsesBefore + 1) begin mismatched++; $display("[TB] FAIL auto_start: got %0d expected 1 pulse", startPulses - pulsesBefore); end
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    hwSel = 4'b0000;
    compared++; if ({startO, finiO} !== 2'b00) begin mismatched++; $display("[TB] FAIL abort_outputs: got %b expected 00", {startO, finiO}); end
    wbRead(ADR_QUOTIENT, r);
    compared++; if (r !== 32'd0) begin mismatched++; $display("[TB] FAIL abort_quotient: got %h expected 0", r); end
    wbRead(ADR_DIVIDEND, r);
    compared++; if (r !== 32'd0) begin mismatched++; $display("[TB] FAIL abort_dividend: got %h expected 0", r); end
    wbRead(ADR_DIVISOR, r);
    compared++; if (r !== 32'd0) begin mismatched++; $display("[TB] FAIL abort_divisor: got %h expected 0", r); end
    wbRead(ADR_STATUS, r);
    compared++; if (r !== 32'd0) begin mismatched++; $display("[TB] FAIL abort_status: got %h expected 0", r); end
  endtask

  task automatic test_byte_sel_decode();
    int acks;
    logic [31:0] r;
    wbWrite(ADR_DIVIDEND, 32'h1122_3344, 4'hF, acks);
    wbWrite(ADR_DIVIDEND, 32'hAABB_CCDD, 4'b0001, acks);
    compared++; if (acks != 1) begin mismatched++; $display("[TB] FAIL single_ack: got %0d expected 1", acks); end
    wbRead(ADR_DIVIDEND, r);
    compared++; if (r !== 32'h1122_33DD) begin mismatched++; $display("[TB] FAIL byte_lane: got %h expected %h", r, 32'h1122_33DD); end
    wbWrite(32'h1100_0000, 32'h0000_FFFF, 4'hF, acks);
    compared++; if (acks != 1) begin mismatched++; $display("[TB] FAIL both_region_ack: got %0d expected 1", acks); end
    wbRead(ADR_DIVIDEND, r);
    compared++; if (r !== 32'h1122_33DD) begin mismatched++; $display("[TB] FAIL both_region_write: got %h expected %h", r, 32'h1122_33DD); end
    wbRead(32'h1100_0000, r);
    compared++; if (r !== 32'd0) begin mismatched++; $display("[TB] FAIL both_region_read: got %h expected 0", r); end
    wbRead(32'h0000_0004, r);
    compared++; if (r !== 32'd0) begin mismatched++; $display("[TB] FAIL no_region_read: got %h expected 0", r); end
  endtask

  task automatic test_blinky();
    int acks, period;
    logic prev;
    logic ok;
    wbWrite(ADR_CONTROL, 32'd2, 4'hF, acks);
    compared++; if (swBlinky !== 1'b1) begin mismatched++; $display("[TB] FAIL sw_blinky_on: got %b expected 1", swBlinky); end
    ok = 1'b0;
    prev = hwBlinky;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (hwBlinky !== prev) ok = 1'b1;
    end
    period = 0;
    prev = hwBlinky;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      period++;
      if (hwBlinky !== prev) break;
    end
    compared++; if (!ok || period != BLINK / 2) begin mismatched++; $display("[TB] FAIL hw_blinky_period: got %0d expected %0d", period, BLINK / 2); end
    wbWrite(ADR_CONTROL, 32'd0, 4'hF, acks);
    compared++; if (swBlinky !== 1'b0) begin mismatched++; $display("[TB] FAIL sw_blinky_off: got %b expected 0", swBlinky); end
  endtask

  // Scenario sequence
  initial begin
    $display("[TB] serial_divider bench starting");
    test_reset();
    test_basic();
    test_divide();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_byte_sel_decode();
    test_blinky();
    test_auto_start_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
